// File: rtl/seg_time_decoder.sv
// seg_time_decoder
// Receiving end of the stopwatch seven-segment display buses. Each new pattern
// must hold steady before it is decoded back to BCD digits and a binary
// tenths count. Successive values are checked for legal advance, and sticky
// flags report non-decimal glyphs and skipped steps.
// All state updates on the falling edge of Clk, matching the counter blocks.
module seg_time_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_COUNT     = 999
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [7:0] S0,
    input  logic [7:0] S1,
    input  logic [7:0] S2,
    input  logic       ClrErr,
    output logic [3:0] Digit0,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [9:0] Tenths,
    output logic       Valid,
    output logic       BadPattern,
    output logic       StepError
);

    localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);
    localparam logic [10:0] MAX    = 11'(MAX_COUNT);

    typedef enum logic {
        WAIT_FIRST,
        TRACK
    } state_t;

    state_t      state;
    logic [20:0] bus;
    logic [20:0] sample;
    logic [20:0] last_raw;
    logic [3:0]  stable_cnt;
    logic        taken;

    logic [4:0]  dec0;
    logic [4:0]  dec1;
    logic [4:0]  dec2;
    logic        digits_ok;
    logic [10:0] value;
    logic        accept;
    logic        step_ok;
    logic        bad_set;
    logic        step_set;

    // Decimal points carry no count information.
    logic        dp_unused;
    assign dp_unused = S0[7] ^ S1[7] ^ S2[7];

    assign bus = {S2[6:0], S1[6:0], S0[6:0]};

    // Glyph to {is_decimal, bcd}; anything outside 0-9 (hex letters, blank)
    // reports is_decimal = 0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        r = '0;
        case (seg)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Decode the held sample and decide whether this edge accepts it.
    always_comb begin
        dec0      = decode_glyph(sample[6:0]);
        dec1      = decode_glyph(sample[13:7]);
        dec2      = decode_glyph(sample[20:14]);
        digits_ok = dec0[4] & dec1[4] & dec2[4];
        value     = 11'(dec2[3:0]) * 11'd100
                  + 11'(dec1[3:0]) * 11'd10
                  + 11'(dec0[3:0]);
        // taken blocks a saturated pattern from being accepted twice; the
        // last_raw compare blocks a pattern that returns after a glitch.
        accept    = (stable_cnt == STABLE) && !taken
                  && ((sample != last_raw) || (state == WAIT_FIRST));
        // The MAX_COUNT -> 0 wrap is covered by the N = 0 term.
        step_ok   = (value <= MAX)
                  && ((state == WAIT_FIRST)
                      || (value == 11'(Tenths) + 11'd1)
                      || (value == '0));
        bad_set   = accept && !digits_ok;
        step_set  = accept && digits_ok && !step_ok;
    end

    // Sample the buses and count how long the current pattern has held.
    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            sample     <= '0;
            stable_cnt <= '0;
            taken      <= 1'b0;
        end else begin
            sample <= bus;
            if (bus == sample) begin
                if (stable_cnt != STABLE) begin
                    stable_cnt <= stable_cnt + 4'd1;
                end
                if (accept) begin
                    taken <= 1'b1;
                end
            end else begin
                stable_cnt <= 4'd1;
                taken      <= 1'b0;
            end
        end
    end

    // Tracking FSM: loads accepted values and maintains the sticky flags.
    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= WAIT_FIRST;
            last_raw   <= '0;
            Digit0     <= '0;
            Digit1     <= '0;
            Digit2     <= '0;
            Tenths     <= '0;
            Valid      <= 1'b0;
            BadPattern <= 1'b0;
            StepError  <= 1'b0;
        end else begin
            Valid      <= 1'b0;
            BadPattern <= (BadPattern & ~ClrErr) | bad_set;
            StepError  <= (StepError & ~ClrErr) | step_set;
            if (accept) begin
                // A bad glyph still becomes last_raw so it is flagged once.
                last_raw <= sample;
                if (digits_ok) begin
                    Digit0 <= dec0[3:0];
                    Digit1 <= dec1[3:0];
                    Digit2 <= dec2[3:0];
                    Tenths <= value[9:0];
                    Valid  <= 1'b1;
                    state  <= TRACK;
                end
            end
        end
    end

endmodule
